// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator for the decode stage.
// Classifies each accepted instruction, emits the sign-extended immediate
// one cycle later behind a valid/ready interface with an optional skid
// entry, a synchronous flush and a saturating illegal-opcode counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SKID  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   imm_o,
  output logic [2:0]        fmt_o,
  output logic              illegal_o,
  output logic [31:0]       instr_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            ill;
    logic [31:0]     instr;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  fmt_e        dec_fmt;
  logic        dec_ill;
  entry_t      dec;

  entry_t      m_q;
  entry_t      s_q;
  logic        m_valid_q;
  logic        s_valid_q;

  logic        accept;
  logic        xfer;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Decode the incoming word into a 32-bit immediate and format; every
  // format fits in 32 bits, so widening to XLEN is a single sign extension.
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    unique case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          imm32   = {26'b0, (XLEN == 64) ? instr_i[25] : 1'b0, instr_i[24:20]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec_fmt = FMT_SHAMT;
            imm32   = {27'b0, instr_i[24:20]};
          end else begin
            dec_fmt = FMT_I;
            imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {instr_i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
      end
      7'b0111011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_R;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec.imm   = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  assign dec.fmt   = dec_fmt;
  assign dec.ill   = dec_ill;
  assign dec.instr = instr_i;

  assign in_ready_o = (SKID != 0) ? !s_valid_q : (!m_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign xfer       = m_valid_q && out_ready_i;

  // Main/skid entry pipeline; flush wins over every other event. With the
  // skid disabled the S branch is never taken because in_ready_o already
  // blocks accepts while M is full and stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '{imm: '0, fmt: FMT_NONE, ill: 1'b0, instr: '0};
      s_q       <= '{imm: '0, fmt: FMT_NONE, ill: 1'b0, instr: '0};
    end else if (flush_i) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else if (s_valid_q && xfer) begin
      m_q       <= s_q;
      m_valid_q <= 1'b1;
      s_valid_q <= 1'b0;
    end else if (accept) begin
      if (!m_valid_q || xfer) begin
        m_q       <= dec;
        m_valid_q <= 1'b1;
      end else if (SKID != 0) begin
        s_q       <= dec;
        s_valid_q <= 1'b1;
      end
    end else if (xfer) begin
      m_valid_q <= 1'b0;
    end
  end

  // Saturating count of accepted illegal instructions; flush does not clear it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_cnt_o <= '0;
    end else if (accept && !flush_i && dec_ill && (illegal_cnt_o != '1)) begin
      illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
    end
  end

  assign out_valid_o = m_valid_q;
  assign imm_o       = m_q.imm;
  assign fmt_o       = m_q.fmt;
  assign illegal_o   = m_q.ill;
  assign instr_o     = m_q.instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 64-bit skid instance (2-bit counter)
// and a 32-bit single-register instance share clock and reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        flush_a, iv_a, ir_a, ov_a, or_a, ill_a;
  logic [31:0] instr_a, io_a;
  logic [63:0] imm_a;
  logic [2:0]  fmt_a;
  logic [1:0]  cnt_a;

  logic        flush_b, iv_b, ir_b, ov_b, or_b, ill_b;
  logic [31:0] instr_b, io_b;
  logic [31:0] imm_b;
  logic [2:0]  fmt_b;
  logic [7:0]  cnt_b;

  imm_gen_pipe #(.XLEN(64), .CNT_W(2), .SKID(1)) dut64 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush_a),
    .in_valid_i(iv_a), .in_ready_o(ir_a), .instr_i(instr_a),
    .out_valid_o(ov_a), .out_ready_i(or_a), .imm_o(imm_a), .fmt_o(fmt_a),
    .illegal_o(ill_a), .instr_o(io_a), .illegal_cnt_o(cnt_a)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(8), .SKID(0)) dut32 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush_b),
    .in_valid_i(iv_b), .in_ready_o(ir_b), .instr_i(instr_b),
    .out_valid_o(ov_b), .out_ready_i(or_b), .imm_o(imm_b), .fmt_o(fmt_b),
    .illegal_o(ill_b), .instr_o(io_b), .illegal_cnt_o(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sel32;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush_a = 0; iv_a = 0; or_a = 1; instr_a = '0;
    flush_b = 0; iv_b = 0; or_b = 1; instr_b = '0;

    vecs.push_back('{1'b0, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0});
    vecs.push_back('{1'b0, 32'h0080006F, 64'h0000000000000008, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 32'h03F09093, 64'h000000000000003F, 3'd6, 1'b0});
    vecs.push_back('{1'b0, 32'h4010D093, 64'h0000000000000001, 3'd6, 1'b0});
    vecs.push_back('{1'b0, 32'hFE20AC23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0});
    vecs.push_back('{1'b0, 32'h002081B3, 64'h0000000000000000, 3'd0, 1'b0});
    vecs.push_back('{1'b0, 32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 32'h03F0909B, 64'h000000000000001F, 3'd6, 1'b0});
    vecs.push_back('{1'b0, 32'h8000A083, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 32'h7FF080E7, 64'h00000000000007FF, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFFF097, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0});
    vecs.push_back('{1'b0, 32'hFFDFF0EF, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0});
    vecs.push_back('{1'b0, 32'h0000003B, 64'h0000000000000000, 3'd0, 1'b0});
    vecs.push_back('{1'b1, 32'h01F09093, 64'h000000000000001F, 3'd6, 1'b0});
    vecs.push_back('{1'b1, 32'h0000009B, 64'h0000000000000000, 3'd7, 1'b1});
    vecs.push_back('{1'b1, 32'h0000003B, 64'h0000000000000000, 3'd7, 1'b1});
    vecs.push_back('{1'b1, 32'hFFF00093, 64'h00000000FFFFFFFF, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 32'hFE000EE3, 64'h00000000FFFFFFFC, 3'd3, 1'b0});

    // Reset state
    #12;
    chk("rst_ov", ov_a, 0);
    chk("rst_ir", ir_a, 1);
    chk("rst_imm", imm_a, 0);
    chk("rst_fmt", fmt_a, 7);
    chk("rst_ill", ill_a, 0);
    chk("rst_instr", io_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ir32", ir_b, 1);
    rst_n = 1'b1;
    tick();

    // Table: one accept per vector, consumer always ready
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].sel32) begin
        instr_b = vecs[i].instr; iv_b = 1'b1;
        tick();
        iv_b = 1'b0;
        chk($sformatf("v%0d_ov", i), ov_b, 1);
        chk($sformatf("v%0d_imm", i), {32'b0, imm_b}, vecs[i].imm);
        chk($sformatf("v%0d_fmt", i), fmt_b, vecs[i].fmt);
        chk($sformatf("v%0d_ill", i), ill_b, vecs[i].ill);
        chk($sformatf("v%0d_instr", i), io_b, vecs[i].instr);
      end else begin
        instr_a = vecs[i].instr; iv_a = 1'b1;
        tick();
        iv_a = 1'b0;
        chk($sformatf("v%0d_ov", i), ov_a, 1);
        chk($sformatf("v%0d_imm", i), imm_a, vecs[i].imm);
        chk($sformatf("v%0d_fmt", i), fmt_a, vecs[i].fmt);
        chk($sformatf("v%0d_ill", i), ill_a, vecs[i].ill);
        chk($sformatf("v%0d_instr", i), io_a, vecs[i].instr);
      end
    end
    tick();
    chk("drain_ov", ov_a, 0);

    // Backpressure with skid: A,B fill M,S; C waits; release delivers A..D in order
    or_a = 0; iv_a = 1; instr_a = 32'h00001037;
    tick();
    chk("bp1_instr", io_a, 32'h00001037);
    chk("bp1_ir", ir_a, 1);
    instr_a = 32'h00002037;
    tick();
    chk("bp2_instr", io_a, 32'h00001037);
    chk("bp2_ir", ir_a, 0);
    instr_a = 32'h00003037;
    tick();
    chk("bp3_ov", ov_a, 1);
    chk("bp3_instr", io_a, 32'h00001037);
    chk("bp3_imm", imm_a, 64'h1000);
    chk("bp3_ir", ir_a, 0);
    or_a = 1;
    tick();
    chk("bp4_instr", io_a, 32'h00002037);
    chk("bp4_imm", imm_a, 64'h2000);
    chk("bp4_ir", ir_a, 1);
    tick();
    chk("bp5_instr", io_a, 32'h00003037);
    chk("bp5_imm", imm_a, 64'h3000);
    instr_a = 32'h00004037;
    tick();
    iv_a = 0;
    chk("bp6_instr", io_a, 32'h00004037);
    chk("bp6_ov", ov_a, 1);
    tick();
    chk("bp7_ov", ov_a, 0);

    // Flush with S full and an input offered
    or_a = 0; iv_a = 1; instr_a = 32'h00001037;
    tick();
    instr_a = 32'h00002037;
    tick();
    chk("fl_full_ir", ir_a, 0);
    flush_a = 1; instr_a = 32'h00003037;
    tick();
    chk("fl_ov", ov_a, 0);
    chk("fl_ir", ir_a, 1);
    or_a = 1; instr_a = 32'h00005037;
    tick();
    flush_a = 0; iv_a = 0;
    chk("fl_drop_ov", ov_a, 0);
    tick();
    chk("fl_drop_ov2", ov_a, 0);

    // Illegal counter with saturation; the flushed one is not counted
    rst_n = 0; #2; rst_n = 1;
    tick();
    chk("cnt_clr", cnt_a, 0);
    flush_a = 1; iv_a = 1; instr_a = 32'h0000007F;
    tick();
    flush_a = 0;
    chk("cnt_flush", cnt_a, 0);
    chk("cnt_flush_ov", ov_a, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("cnt%0d", k), cnt_a, (k < 3) ? k + 1 : 3);
      chk($sformatf("cnt%0d_ill", k), ill_a, 1);
      chk($sformatf("cnt%0d_fmt", k), fmt_a, 7);
    end
    iv_a = 0;
    tick();

    // 32-bit, no skid: ready follows consumer; back-to-back accept on transfer
    or_b = 0; iv_b = 1; instr_b = 32'h00001037;
    tick();
    chk("ns_ov", ov_b, 1);
    chk("ns_ir_stall", ir_b, 0);
    or_b = 1;
    #1;
    chk("ns_ir_go", ir_b, 1);
    instr_b = 32'h00002037;
    tick();
    iv_b = 0;
    chk("ns_b2b_instr", io_b, 32'h00002037);
    chk("ns_b2b_imm", {32'b0, imm_b}, 64'h2000);
    tick();
    chk("ns_drain", ov_b, 0);

    // Asynchronous reset between edges, then one-cycle latency afterwards
    or_a = 0; iv_a = 1; instr_a = 32'h00005037;
    tick();
    iv_a = 0;
    chk("ar_pre_ov", ov_a, 1);
    #3 rst_n = 0;
    #1;
    chk("ar_ov", ov_a, 0);
    chk("ar_ir", ir_a, 1);
    chk("ar_imm", imm_a, 0);
    chk("ar_fmt", fmt_a, 7);
    chk("ar_instr", io_a, 0);
    chk("ar_cnt", cnt_a, 0);
    #2 rst_n = 1;
    tick();
    chk("ar_idle", ov_a, 0);
    or_a = 1; iv_a = 1; instr_a = 32'h00006037;
    tick();
    iv_a = 0;
    chk("ar_lat_ov", ov_a, 1);
    chk("ar_lat_imm", imm_a, 64'h6000);
    chk("ar_lat_instr", io_a, 32'h00006037);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage of the pipelined RISC-V core. It accepts one 32-bit instruction per handshake and classifies it as R/I/S/B/U/J/shift-amount. It emits the sign-extended XLEN-bit immediate one cycle later with a valid/ready interface, a skid buffer, a flush, and a saturating illegal-opcode counter.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
CNT_W, 8, width of the illegal-instruction counter.
SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with in_ready_o = !out_valid_o | out_ready_i.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
flush_i  in  1  synchronous pipeline flush.
in_valid_i  in  1  instruction valid.
in_ready_o  out  1  block can accept.
instr_i  in  32  instruction word.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts.
imm_o  out  XLEN  immediate.
fmt_o  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 NONE.
illegal_o  out  1  opcode not recognised.
instr_o  out  32  instruction passed through with its result.
illegal_cnt_o  out  CNT_W  count of accepted illegal instructions, saturating.

Behaviour:
- Reset (rst_i low, async): out_valid_o=0, skid valid=0, imm_o=0, fmt_o=7, illegal_o=0, instr_o=0, illegal_cnt_o=0, in_ready_o=1.
- Decode on opcode instr_i[6:0]:
  - 0010011 (OP-IMM) with funct3 001 or 101: SHAMT. imm = zero-extended shamt; shamt is instr[25:20] if XLEN=64, else instr[24:20].
  - 0010011 (other funct3), 0000011, 1100111: I. imm = sext(instr[31:20]).
  - 0011011 (OP-IMM-32), XLEN=64 only: funct3 001/101 gives SHAMT with imm = zext(instr[24:20]); otherwise I. When XLEN=32 this opcode is illegal.
  - 0100011: S. imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: B. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111: U. imm = sext({instr[31:12], 12'b0}).
  - 1101111: J. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011, and 0111011 when XLEN=64: R. imm = 0.
  - Anything else: fmt 7, imm = 0, illegal = 1.
- Latency: instruction accepted at edge N appears on the outputs after edge N (one cycle). Results are never combinational from instr_i.
- Handshakes:
  - Accept = in_valid_i & in_ready_o.
  - Output transfer = out_valid_o & out_ready_i.
  - Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- SKID=1: main register M, skid register S; in_ready_o = !S.valid (registered).
  - Accept with M empty or M transferring: load M.
  - Accept with M full and not transferring: load S.
  - Transfer with S valid: M <= S, S cleared.
  - Order is strictly preserved; sustained throughput is 1/cycle.
- SKID=0: M only. Back-to-back accept while M transfers in the same cycle is permitted.
- Flush: flush_i=1 clears M.valid and S.valid at the edge. Any accept in that cycle is dropped and is not counted. Flush has priority over every other event. imm_o, fmt_o and instr_o may retain stale values.
- Counter: increments by 1 on each accepted (non-dropped) illegal instruction and saturates at 2^CNT_W-1. It is cleared only by reset, not by flush.
- Reset asserted mid-stream: all in-flight entries are lost immediately; no output transfer is reported.

Test Plan:
1. Single accept, out_ready_i=1. Send 0xFFF00093, 0x123450B7, 0x0080006F, 0xFE000EE3 (XLEN=64) -> one cycle later, in order: imm 0xFFFFFFFFFFFFFFFF fmt1; 0x0000000012345000 fmt4; 0x8 fmt5; 0xFFFFFFFFFFFFFFFC fmt3.
2. Shift forms. Send 0x03F09093 (slli x1,x1,63) -> imm 0x3F fmt6. Send 0x4010D093 (srai x1,x1,1) -> imm 0x1 fmt6. With XLEN=32: 0x01F09093 -> imm 0x1F, and opcode 0011011 -> illegal_o=1.
3. Backpressure, SKID=1. Stream 4 instructions, hold out_ready_i=0 for 3 cycles -> M and S fill, in_ready_o=0 from the following cycle, outputs held stable. Release -> all 4 delivered in order, with no loss or duplication.
4. Flush with S full plus in_valid_i=1 in the same cycle -> next cycle out_valid_o=0, in_ready_o=1, and no output for the dropped instruction.
5. Illegal counter, CNT_W=2. Send 5 instructions with opcode 0x7F -> illegal_cnt_o reads 1, 2, 3, 3, 3 and illegal_o=1 each time. One of them accepted during flush -> not counted.
6. Async reset asserted mid-stream between clock edges -> outputs reach reset values immediately. After deassertion, the first instruction completes with 1-cycle latency.
